hc194_seq_ctrl: RTL and testbench
=================================

// Module: hc194_seq_ctrl
// PURPOSE
//  Command sequencer for the 4-bit HC194 universal shift register.
//  Accepts load/shift/clear commands over a valid/ready handshake and drives S, DSR, DSL, D.
//  Runs multi-cycle shifts (serial in, or rotate) and streams the shifted-out bits.
//  Sits between the host logic and one HC194 instance; both share clock CP.
// PARAMETERS
//  CNT_W   4   width of shift count; max shifts per command = 2**CNT_W-1
// PORTS
//  CP         in   1      clock; all state updates on rising edge
//  MR         in   1      reset, synchronous, active-high
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      controller can accept a command (high only in IDLE)
//  cmd_op     in   2      00 LOAD, 01 SHR (toward Q[3]), 10 SHL (toward Q[0]), 11 CLEAR
//  cmd_cnt    in   CNT_W  number of shifts for SHR/SHL; ignored for LOAD/CLEAR
//  cmd_rot    in   1      1 = rotate (feed exiting bit back), 0 = feed ser_in
//  cmd_data   in   4      parallel word for LOAD, index [0:3] as the HC194 D
//  ser_in     in   1      serial input bit for non-rotate shifts
//  sr_q       in   4      HC194 Q feedback [0:3]
//  sr_s       out  2      HC194 mode select (00 hold, 01 right, 10 left, 11 load)
//  sr_dsr     out  1      HC194 DSR
//  sr_dsl     out  1      HC194 DSL
//  sr_d       out  4      HC194 parallel data [0:3]
//  ser_out    out  1      bit leaving the register this cycle
//  ser_vld    out  1      ser_out valid (high every SHIFT cycle)
//  busy       out  1      command in progress (state != IDLE)
//  done       out  1      one-cycle pulse: command finished
// BEHAVIOUR
//  - States: IDLE, LOAD, SHIFT, DONE. State and the down-counter are registered.
//    sr_* outputs are decoded combinationally from the registered state.
//  - Reset (MR=1 at an edge): state=IDLE, cnt=0, latched op/rot/data=0.
//    Outputs: sr_s=00, sr_dsr=0, sr_dsl=0, sr_d=0, ser_out=0, ser_vld=0, busy=0, done=0, cmd_ready=1.
//    MR aborts any command mid-operation with no done pulse.
//    The HC194 contents are not touched by MR; S=00 holds them.
//  - Accept: cmd_valid & cmd_ready at edge k latches op/cnt/rot/data.
//  - IDLE: sr_s=00.
//    On accept: LOAD/CLEAR go to LOAD; SHR/SHL with cnt>0 go to SHIFT; cnt==0 goes straight to DONE.
//  - LOAD (1 cycle): sr_s=11; sr_d=cmd_data (LOAD) or 4'b0000 (CLEAR). HC194 loads at the next edge. Then DONE.
//  - SHIFT: sr_s=01 (SHR) or 10 (SHL); ser_vld=1.
//    SHR: ser_out=sr_q[3]; sr_dsr = rot ? sr_q[3] : ser_in.
//    SHL: ser_out=sr_q[0]; sr_dsl = rot ? sr_q[0] : ser_in.
//    cnt decrements each edge; on the edge where cnt==1 go to DONE.
//    Exactly cnt HC194 shifts occur.
//  - DONE (1 cycle): sr_s=00, done=1, busy=1, cmd_ready=0. Then IDLE.
//  - Latency (accept edge k): LOAD/CLEAR done in cycle k+1..k+2.
//    Shift n>0: SHIFT cycles k+1..k+n, done at k+n+1.
//  - Outside SHIFT: sr_dsr/sr_dsl/ser_out=0. Outside LOAD: sr_d=0.
//  - cmd_* inputs are ignored while cmd_ready=0; no queuing.
// CONFIGURATION
//  HC194_SEQ_ABORT_EN defined:
//    - adds input port `abort` (1 bit).
//    - abort=1 in SHIFT: the current cycle is the last shift; next state is DONE.
//    - abort in LOAD/DONE/IDLE is ignored.
//    - done pulses normally.
//  Not defined: port `abort` absent; SHIFT always runs to cnt==0.
// TESTING
//  1. MR=1 during SHIFT (cnt=5, after 2 shifts) -> next cycle IDLE, sr_s=00, busy=0, done=0, no done pulse.
//  2. LOAD cmd_data=4'b1011 -> one cycle sr_s=11, sr_d=1011; Q=1011 after; done one cycle later.
//  3. SHR cnt=4 rot=0, Q=1011, ser_in=0 -> ser_out 1,1,0,1 over 4 cycles; Q=0000; done at k+5.
//  4. SHL cnt=3 rot=1, Q=1000 -> Q 0001,0010,0100; ser_out 1,0,0; done pulse.
//  5. SHR cnt=0 -> no S=01 cycle, done at k+1; then CLEAR -> Q=0000.
//  6. [HC194_SEQ_ABORT_EN] SHL cnt=10, abort in 3rd SHIFT cycle -> exactly 3 shifts, then done.

Source files
------------

// File: rtl/hc194_seq_ctrl.sv
// Command sequencer driving one HC194 universal shift register (load / shift / clear).
// Optional shift abort input is enabled by defining HC194_SEQ_ABORT_EN.
module hc194_seq_ctrl #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             cmd_rot,
    input  logic [0:3]       cmd_data,
    input  logic             ser_in,
    input  logic [0:3]       sr_q,
`ifdef HC194_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [1:0]       sr_s,
    output logic             sr_dsr,
    output logic             sr_dsl,
    output logic [0:3]       sr_d,
    output logic             ser_out,
    output logic             ser_vld,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpShr   = 2'b01;
    localparam logic [1:0] OpShl   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    localparam logic [1:0] ModeHold  = 2'b00;
    localparam logic [1:0] ModeRight = 2'b01;
    localparam logic [1:0] ModeLeft  = 2'b10;
    localparam logic [1:0] ModeLoad  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             rot_q, rot_d;
    logic [0:3]       data_q, data_d;
    logic             abort_hit;

`ifdef HC194_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_ff @(posedge CP) begin
        if (MR) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= OpLoad;
            rot_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rot_q   <= rot_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rot_d   = rot_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_cnt;
                    rot_d  = cmd_rot;
                    data_d = cmd_data;
                    if (cmd_op == OpLoad || cmd_op == OpClear) begin
                        state_d = StLoad;
                    end else if (cmd_cnt == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StLoad: state_d = StDone;
            StShift: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Abort makes the current cycle the final shift.
                if (cnt_q == CNT_W'(1) || abort_hit) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        sr_s      = ModeHold;
        sr_dsr    = 1'b0;
        sr_dsl    = 1'b0;
        sr_d      = '0;
        ser_out   = 1'b0;
        ser_vld   = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: ;
            StLoad: begin
                sr_s = ModeLoad;
                sr_d = (op_q == OpLoad) ? data_q : 4'b0000;
            end
            StShift: begin
                ser_vld = 1'b1;
                if (op_q == OpShl) begin
                    sr_s    = ModeLeft;
                    ser_out = sr_q[0];
                    sr_dsl  = rot_q ? sr_q[0] : ser_in;
                end else begin
                    sr_s    = ModeRight;
                    ser_out = sr_q[3];
                    sr_dsr  = rot_q ? sr_q[3] : ser_in;
                end
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

    logic unused_op;
    assign unused_op = (op_q == OpShr);

endmodule

// File: tb/tb_hc194_seq_ctrl.sv
// Bench for hc194_seq_ctrl: a behavioural HC194 closes the loop; table vectors,
// hand sequences for reset/abort, and random commands against a queue-based model.
module tb_hc194_seq_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             CP;
    logic             MR;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_rot;
    logic [0:3]       cmd_data;
    logic             ser_in;
    logic [0:3]       sr_q;
    logic             abort;
    logic [1:0]       sr_s;
    logic             sr_dsr;
    logic             sr_dsl;
    logic [0:3]       sr_d;
    logic             ser_out;
    logic             ser_vld;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    hc194_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .CP        (CP),
        .MR        (MR),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_rot   (cmd_rot),
        .cmd_data  (cmd_data),
        .ser_in    (ser_in),
        .sr_q      (sr_q),
`ifdef HC194_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .sr_s      (sr_s),
        .sr_dsr    (sr_dsr),
        .sr_dsl    (sr_dsl),
        .sr_d      (sr_d),
        .ser_out   (ser_out),
        .ser_vld   (ser_vld),
        .busy      (busy),
        .done      (done)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    // Behavioural HC194: Q[0] receives DSR on right shift, Q[3] receives DSL on left shift.
    always_ff @(posedge CP) begin
        case (sr_s)
            2'b01:   sr_q <= {sr_dsr, sr_q[0:2]};
            2'b10:   sr_q <= {sr_q[1:3], sr_dsl};
            2'b11:   sr_q <= sr_d;
            default: sr_q <= sr_q;
        endcase
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] cnt;
        logic       rot;
        logic [0:3] data;
        logic       sin;
        logic [0:3] exp_q;
        logic [15:0] exp_ser;
        int         exp_lat;
        int         exp_shifts;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and follow it to completion, recording what the DUT did.
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic rot,
                           input logic [0:3] data, input logic [15:0] bits,
                           input int abort_at, output logic [0:3] q_after,
                           output logic [15:0] ser, output int lat, output int shifts,
                           output bit ok);
        ok = 1'b1;
        ser = '0;
        lat = -1;
        shifts = 0;
        q_after = 'x;
        @(posedge CP); #1;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_cnt = cnt;
        cmd_rot = rot;
        cmd_data = data;
        ser_in = bits[0];
        abort = 1'b0;
        @(posedge CP); #1;
        // Random traffic while busy must be ignored.
        cmd_valid = 1'($urandom);
        cmd_op = 2'($urandom);
        cmd_cnt = 4'($urandom);
        cmd_rot = 1'($urandom);
        cmd_data = 4'($urandom);
        ser_in = bits[0];
        abort = (abort_at == 1);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge CP);
            if (!busy || cmd_ready) ok = 1'b0;
            if (sr_s == 2'b11) begin
                if (sr_d !== ((op == 2'b00) ? data : 4'b0000)) ok = 1'b0;
            end else if (sr_d !== 4'b0000) begin
                ok = 1'b0;
            end
            if (sr_s == 2'b01 || sr_s == 2'b10) begin
                if (!ser_vld || done) ok = 1'b0;
                ser = {ser[14:0], ser_out};
                shifts++;
            end else if (ser_vld || ser_out || sr_dsr || sr_dsl) begin
                ok = 1'b0;
            end
            if (done) begin
                lat = c;
                q_after = sr_q;
                if (sr_s !== 2'b00) ok = 1'b0;
                cmd_valid = 1'b0;
                abort = 1'b0;
            end else begin
                @(posedge CP); #1;
                ser_in = bits[shifts[3:0]];
                abort = (c + 1 == abort_at);
            end
        end
        cmd_valid = 1'b0;
        abort = 1'b0;
        @(posedge CP);
        @(negedge CP);
        if (!cmd_ready || busy || done) ok = 1'b0;
    endtask

    // Reference: the register is a queue with the exiting bit at the front.
    function automatic void model(input logic [1:0] op, input logic [3:0] cnt, input logic rot,
                                  input logic [0:3] data, input logic [15:0] bits,
                                  input logic [0:3] q0, output logic [0:3] q,
                                  output logic [15:0] ser, output int lat, output int shifts);
        logic qq[$];
        logic b;
        ser = '0;
        shifts = 0;
        q = q0;
        if (op == 2'b00 || op == 2'b11) begin
            q = (op == 2'b00) ? data : 4'b0000;
            lat = 2;
        end else begin
            for (int i = 0; i < 4; i++) qq.push_back((op == 2'b01) ? q0[3-i] : q0[i]);
            for (int i = 0; i < int'(cnt); i++) begin
                b = qq.pop_front();
                ser = {ser[14:0], b};
                qq.push_back(rot ? b : bits[i]);
            end
            for (int i = 0; i < 4; i++) q[i] = (op == 2'b01) ? qq[3-i] : qq[i];
            shifts = int'(cnt);
            lat = (cnt == 0) ? 1 : int'(cnt) + 1;
        end
    endfunction

    vec_t tbl[9];
    logic [0:3]  q_act, q_exp, q_start;
    logic [15:0] ser_act, ser_exp, bits;
    int          lat_act, lat_exp, sh_act, sh_exp;
    bit          ok;
    bit          saw_done;

    initial begin
        tbl[0] = '{2'b00, 4'd0, 1'b0, 4'b1011, 1'b0, 4'b1011, 16'h0000, 2, 0};
        tbl[1] = '{2'b01, 4'd4, 1'b0, 4'b0000, 1'b0, 4'b0000, 16'h000D, 5, 4};
        tbl[2] = '{2'b00, 4'd0, 1'b0, 4'b1000, 1'b0, 4'b1000, 16'h0000, 2, 0};
        tbl[3] = '{2'b10, 4'd3, 1'b1, 4'b0000, 1'b0, 4'b0100, 16'h0004, 4, 3};
        tbl[4] = '{2'b01, 4'd0, 1'b0, 4'b0000, 1'b0, 4'b0100, 16'h0000, 1, 0};
        tbl[5] = '{2'b11, 4'd0, 1'b0, 4'b1111, 1'b0, 4'b0000, 16'h0000, 2, 0};
        tbl[6] = '{2'b00, 4'd0, 1'b0, 4'b0110, 1'b0, 4'b0110, 16'h0000, 2, 0};
        tbl[7] = '{2'b01, 4'd2, 1'b1, 4'b0000, 1'b0, 4'b1001, 16'h0001, 3, 2};
        tbl[8] = '{2'b10, 4'd5, 1'b0, 4'b0000, 1'b1, 4'b1111, 16'h0013, 6, 5};

        MR = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_cnt = '0;
        cmd_rot = 1'b0;
        cmd_data = '0;
        ser_in = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge CP);
        @(negedge CP);
        check("reset sr_s", 32'(sr_s), 32'd0);
        check("reset sr_d", 32'(sr_d), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset cmd_ready", 32'(cmd_ready), 32'd1);
        check("reset ser_vld", 32'({ser_vld, ser_out, sr_dsr, sr_dsl}), 32'd0);
        MR = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].op, tbl[i].cnt, tbl[i].rot, tbl[i].data, {16{tbl[i].sin}}, 0,
                    q_act, ser_act, lat_act, sh_act, ok);
            check($sformatf("vec%0d q", i), 32'(q_act), 32'(tbl[i].exp_q));
            check($sformatf("vec%0d ser", i), 32'(ser_act), 32'(tbl[i].exp_ser));
            check($sformatf("vec%0d latency", i), lat_act, tbl[i].exp_lat);
            check($sformatf("vec%0d shifts", i), sh_act, tbl[i].exp_shifts);
            check($sformatf("vec%0d protocol", i), 32'(ok), 32'd1);
        end

        // MR after two shifts of a five-shift command: abort with no done pulse.
        @(posedge CP); #1;
        cmd_valid = 1'b1;
        cmd_op = 2'b01;
        cmd_cnt = 4'd5;
        cmd_rot = 1'b0;
        ser_in = 1'b0;
        @(posedge CP); #1;
        cmd_valid = 1'b0;
        @(negedge CP);
        check("mr pre shift", 32'(sr_s), 32'd1);
        @(posedge CP); #1;
        @(posedge CP); #1;
        MR = 1'b1;
        @(posedge CP); #1;
        MR = 1'b0;
        @(negedge CP);
        check("mr sr_s", 32'(sr_s), 32'd0);
        check("mr busy", 32'(busy), 32'd0);
        check("mr ready", 32'(cmd_ready), 32'd1);
        saw_done = done;
        repeat (8) begin
            @(negedge CP);
            if (done || busy) saw_done = 1'b1;
        end
        check("mr no done", 32'(saw_done), 32'd0);

`ifdef HC194_SEQ_ABORT_EN
        run_cmd(2'b00, 4'd0, 1'b0, 4'b1000, 16'h0, 0, q_act, ser_act, lat_act, sh_act, ok);
        check("abort preload", 32'(q_act), 32'(4'b1000));
        run_cmd(2'b10, 4'd10, 1'b1, 4'b0000, 16'h0, 3, q_act, ser_act, lat_act, sh_act, ok);
        check("abort q", 32'(q_act), 32'(4'b0100));
        check("abort ser", 32'(ser_act), 32'h4);
        check("abort latency", lat_act, 4);
        check("abort shifts", sh_act, 3);
        check("abort protocol", 32'(ok), 32'd1);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [3:0] cnt;
            logic       rot;
            logic [0:3] data;
            op = 2'($urandom);
            cnt = 4'($urandom);
            rot = 1'($urandom);
            data = 4'($urandom);
            bits = 16'($urandom);
            q_start = sr_q;
            model(op, cnt, rot, data, bits, q_start, q_exp, ser_exp, lat_exp, sh_exp);
            run_cmd(op, cnt, rot, data, bits, 0, q_act, ser_act, lat_act, sh_act, ok);
            check($sformatf("rnd%0d q", i), 32'(q_act), 32'(q_exp));
            check($sformatf("rnd%0d ser", i), 32'(ser_act), 32'(ser_exp));
            check($sformatf("rnd%0d latency", i), lat_act, lat_exp);
            check($sformatf("rnd%0d shifts", i), sh_act, sh_exp);
            check($sformatf("rnd%0d protocol", i), 32'(ok), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
